dds_tune_ctrl: RTL and testbench

- Front-panel control stage sitting directly upstream of the DDS core.
- Debounces the raw board push-keys and turns presses into the DDS frequency tuning word (`data`) and the waveform select (`choose`).
- Replaces the fixed power-up tuning word with a user-adjustable, saturating value.
- Tuning word changes in a selectable step size; mode cycles sine/AM/FM/ASK/FSK.

---
 rtl/dds_tune_ctrl_if.sv | 24 ++
 rtl/dds_tune_ctrl.sv | 125 ++++++++++++
 tb/tb_dds_tune_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dds_tune_ctrl_if.sv
// Front-panel key inputs and DDS tuning outputs of dds_tune_ctrl.
// The slave side is the controller; the master side is whatever drives the keys.
interface dds_tune_ctrl_if #(
  parameter int N = 16
);
  logic         key_up_n;
  logic         key_down_n;
  logic         key_mode_n;
  logic         key_step_n;
  logic [N-1:0] data;
  logic [2:0]   choose;
  logic [1:0]   step_sel;
  logic         ftw_update;

  modport master (
    output key_up_n, key_down_n, key_mode_n, key_step_n,
    input  data, choose, step_sel, ftw_update
  );

  modport slave (
    input  key_up_n, key_down_n, key_mode_n, key_step_n,
    output data, choose, step_sel, ftw_update
  );
endinterface

// File: rtl/dds_tune_ctrl.sv
// Key debounce and tuning-word / waveform-select control for the DDS core.
// Key index order: 0 up, 1 down, 2 mode, 3 step.
module dds_tune_ctrl #(
  parameter int           N          = 16,
  parameter int           DEB_CYCLES = 500000,
  parameter logic [N-1:0] FTW_RESET  = 16'h0080,
  parameter logic [N-1:0] FTW_MIN    = 16'h0010,
  parameter logic [N-1:0] FTW_MAX    = 16'h4000
) (
  input  logic            clk,
  input  logic            reset,
  dds_tune_ctrl_if.slave  bus
);
  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [3:0]   raw_s;
  logic [3:0]   sync1_r, sync2_r, deb_r, deb_d_r, armed_r;
  logic [CW-1:0] cnt_r     [0:3];
  logic [CW-1:0] arm_cnt_r [0:3];
  logic [3:0]   press_s;

  logic [N-1:0] data_r, next_data_s, step_s;
  logic [2:0]   choose_r;
  logic [1:0]   step_sel_r;
  logic         ftw_update_r;
  logic [N:0]   sum_s, floor_s;

  assign raw_s   = {bus.key_step_n, bus.key_mode_n, bus.key_down_n, bus.key_up_n};
  // A key only produces events once it has been seen stably released after reset.
  assign press_s = armed_r & deb_d_r & ~deb_r;

  // Synchronise, debounce and arm each key independently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
      deb_r   <= 4'b1111;
      deb_d_r <= 4'b1111;
      armed_r <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        cnt_r[k]     <= '0;
        arm_cnt_r[k] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int k = 0; k < 4; k++) begin
        if (sync2_r[k] == deb_r[k]) begin
          cnt_r[k] <= '0;
        end else if (cnt_r[k] == DEB_LAST) begin
          deb_r[k] <= sync2_r[k];
          cnt_r[k] <= '0;
        end else begin
          cnt_r[k] <= cnt_r[k] + CW'(1);
        end

        if (armed_r[k]) begin
          arm_cnt_r[k] <= '0;
        end else if (deb_r[k] && sync2_r[k]) begin
          if (arm_cnt_r[k] == DEB_LAST) begin
            armed_r[k]   <= 1'b1;
            arm_cnt_r[k] <= '0;
          end else begin
            arm_cnt_r[k] <= arm_cnt_r[k] + CW'(1);
          end
        end else begin
          arm_cnt_r[k] <= '0;
        end
      end
    end
  end

  // Saturating next tuning word; simultaneous up and down cancel out.
  always_comb begin
    step_s      = N'(1) << {step_sel_r, 2'b00};
    sum_s       = {1'b0, data_r} + {1'b0, step_s};
    floor_s     = {1'b0, FTW_MIN} + {1'b0, step_s};
    next_data_s = data_r;
    if (press_s[0] && !press_s[1]) begin
      if (sum_s > {1'b0, FTW_MAX}) begin
        next_data_s = FTW_MAX;
      end else begin
        next_data_s = sum_s[N-1:0];
      end
    end else if (press_s[1] && !press_s[0]) begin
      if ({1'b0, data_r} < floor_s) begin
        next_data_s = FTW_MIN;
      end else begin
        next_data_s = data_r - step_s;
      end
    end else begin
      next_data_s = data_r;
    end
  end

  // Registered outputs to the DDS core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r       <= FTW_RESET;
      choose_r     <= 3'd0;
      step_sel_r   <= 2'd0;
      ftw_update_r <= 1'b0;
    end else begin
      data_r       <= next_data_s;
      ftw_update_r <= (next_data_s != data_r);
      if (press_s[2]) begin
        choose_r <= (choose_r >= 3'd4) ? 3'd0 : choose_r + 3'd1;
      end else begin
        choose_r <= choose_r;
      end
      if (press_s[3]) begin
        step_sel_r <= step_sel_r + 2'd1;
      end else begin
        step_sel_r <= step_sel_r;
      end
    end
  end

  assign bus.data       = data_r;
  assign bus.choose     = choose_r;
  assign bus.step_sel   = step_sel_r;
  assign bus.ftw_update = ftw_update_r;
endmodule

// File: tb/tb_dds_tune_ctrl.sv
// Scoreboard bench for dds_tune_ctrl with DEB_CYCLES=4: stimulus queues the
// expected output state, a negedge monitor pops it whenever the outputs move.
module tb_dds_tune_ctrl;
  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  choose;
    logic [1:0]  step_sel;
    logic        upd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;
  exp_t sb_q[$];

  logic [15:0] last_d = 16'h0080;
  logic [2:0]  last_c = 3'd0;
  logic [1:0]  last_s = 2'd0;

  dds_tune_ctrl_if #(.N(16)) intf ();

  dds_tune_ctrl #(
    .N(16), .DEB_CYCLES(4),
    .FTW_RESET(16'h0080), .FTW_MIN(16'h0010), .FTW_MAX(16'h4000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(intf.slave)
  );

  always #5 clk = ~clk;

  // Monitor: any output movement or ftw_update pulse consumes one expectation.
  logic [15:0] pd = 16'h0080;
  logic [2:0]  pc = 3'd0;
  logic [1:0]  ps = 2'd0;
  always @(negedge clk) begin
    if (started) begin
      if (intf.data != pd || intf.choose != pc || intf.step_sel != ps || intf.ftw_update) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: data=%h choose=%0d step=%0d upd=%b, required no change",
                   intf.data, intf.choose, intf.step_sel, intf.ftw_update);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (intf.data != e.data || intf.choose != e.choose ||
              intf.step_sel != e.step_sel || intf.ftw_update != e.upd) begin
            bad++;
            $display("FAIL sb_entry: got data=%h choose=%0d step=%0d upd=%b, required data=%h choose=%0d step=%0d upd=%b",
                     intf.data, intf.choose, intf.step_sel, intf.ftw_update,
                     e.data, e.choose, e.step_sel, e.upd);
          end
        end
      end
      pd = intf.data;
      pc = intf.choose;
      ps = intf.step_sel;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic expect_state(input logic [15:0] d, input logic [2:0] c, input logic [1:0] s,
                              input bit is_reset);
    exp_t e;
    if (d != last_d || c != last_c || s != last_s) begin
      e.data     = d;
      e.choose   = c;
      e.step_sel = s;
      e.upd      = (!is_reset) && (d != last_d);
      sb_q.push_back(e);
    end
    last_d = d;
    last_c = c;
    last_s = s;
  endtask

  task automatic set_keys(input logic [3:0] mask);
    intf.key_up_n   = ~mask[0];
    intf.key_down_n = ~mask[1];
    intf.key_mode_n = ~mask[2];
    intf.key_step_n = ~mask[3];
  endtask

  task automatic press(input logic [3:0] mask, input logic [15:0] d,
                       input logic [2:0] c, input logic [1:0] s);
    expect_state(d, c, s, 1'b0);
    @(negedge clk); #2;
    set_keys(mask);
    repeat (20) @(posedge clk);
    #2 set_keys(4'b0000);
    repeat (15) @(posedge clk);
    #1 check("queue_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    expect_state(16'h0080, 3'd0, 2'd0, 1'b1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1 check("reset_outputs", {11'd0, intf.ftw_update, intf.step_sel, intf.choose, intf.data},
             {11'd0, 1'b0, 2'd0, 3'd0, 16'h0080});
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    set_keys(4'b0000);
    repeat (3) @(posedge clk);
    #1 check("initial_reset", {11'd0, intf.ftw_update, intf.step_sel, intf.choose, intf.data},
             {11'd0, 1'b0, 2'd0, 3'd0, 16'h0080});
    #1 reset = 1'b0;
    started = 1'b1;
    repeat (10) @(posedge clk);

    // Test 1: single up press, latency of seven edges.
    expect_state(16'h0081, 3'd0, 2'd0, 1'b0);
    @(negedge clk); #2;
    set_keys(4'b0001);
    repeat (6) @(posedge clk);
    #1 check("lat_before", 32'(intf.data), 32'h0080);
    @(posedge clk);
    #1 check("lat_data", 32'(intf.data), 32'h0081);
    check("lat_upd", 32'(intf.ftw_update), 32'd1);
    @(posedge clk);
    #1 check("upd_one_cycle", 32'(intf.ftw_update), 32'd0);
    repeat (12) @(posedge clk);
    #2 set_keys(4'b0000);
    repeat (15) @(posedge clk);
    #1 check("t1_drained", 32'(sb_q.size()), 32'd0);

    // Test 2: three-clock glitch is rejected.
    @(negedge clk); #2;
    set_keys(4'b0001);
    repeat (3) @(posedge clk);
    #2 set_keys(4'b0000);
    repeat (20) @(posedge clk);
    #1 check("glitch_data", 32'(intf.data), 32'h0081);

    // Test 3: step 4096 with saturation at FTW_MAX.
    do_reset();
    press(4'b1000, 16'h0080, 3'd0, 2'd1);
    press(4'b1000, 16'h0080, 3'd0, 2'd2);
    press(4'b1000, 16'h0080, 3'd0, 2'd3);
    press(4'b0001, 16'h1080, 3'd0, 2'd3);
    press(4'b0001, 16'h2080, 3'd0, 2'd3);
    press(4'b0001, 16'h3080, 3'd0, 2'd3);
    press(4'b0001, 16'h4000, 3'd0, 2'd3);
    press(4'b0001, 16'h4000, 3'd0, 2'd3);

    // Test 4: step 16 down to FTW_MIN.
    do_reset();
    press(4'b1000, 16'h0080, 3'd0, 2'd1);
    press(4'b0010, 16'h0070, 3'd0, 2'd1);
    press(4'b0010, 16'h0060, 3'd0, 2'd1);
    press(4'b0010, 16'h0050, 3'd0, 2'd1);
    press(4'b0010, 16'h0040, 3'd0, 2'd1);
    press(4'b0010, 16'h0030, 3'd0, 2'd1);
    press(4'b0010, 16'h0020, 3'd0, 2'd1);
    press(4'b0010, 16'h0010, 3'd0, 2'd1);
    press(4'b0010, 16'h0010, 3'd0, 2'd1);

    // Test 5: mode cycling leaves data alone.
    press(4'b0100, 16'h0010, 3'd1, 2'd1);
    press(4'b0100, 16'h0010, 3'd2, 2'd1);
    press(4'b0100, 16'h0010, 3'd3, 2'd1);
    press(4'b0100, 16'h0010, 3'd4, 2'd1);
    press(4'b0100, 16'h0010, 3'd0, 2'd1);
    press(4'b0100, 16'h0010, 3'd1, 2'd1);

    // Test 6: up+down cancel, then reset during a mode debounce with key held.
    do_reset();
    press(4'b0100, 16'h0080, 3'd1, 2'd0);
    press(4'b0001, 16'h0081, 3'd1, 2'd0);
    press(4'b0011, 16'h0081, 3'd1, 2'd0);
    @(negedge clk); #2;
    set_keys(4'b0100);
    repeat (3) @(posedge clk);
    expect_state(16'h0080, 3'd0, 2'd0, 1'b1);
    #2 reset = 1'b1;
    #1 check("mid_deb_reset", {11'd0, intf.ftw_update, intf.step_sel, intf.choose, intf.data},
             {11'd0, 1'b0, 2'd0, 3'd0, 16'h0080});
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (30) @(posedge clk);
    #1 check("held_no_mode", 32'(intf.choose), 32'd0);
    #1 set_keys(4'b0000);
    repeat (15) @(posedge clk);
    press(4'b0100, 16'h0080, 3'd1, 2'd0);

    repeat (5) @(posedge clk);
    #1 check("final_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
